// File: rtl/fft_pkg.sv
// Shared FFT datapath widths, twiddle format and the elaboration-time
// twiddle generator used by twiddle_rom.
package fft_pkg;

   localparam int DATA_W  = 16;
   localparam int TW_W    = 16;
   localparam int TW_ONE  = 16384;               // Q1.14 unity
   localparam int PROD_W  = DATA_W + TW_W;       // one partial product
   localparam int SUM_W   = PROD_W + 1;          // sum of two products
   localparam int OUT_LSB = 15;                  // 1/2 scale into the adder stage

   localparam logic [SUM_W-1:0] ROUND_BIAS = SUM_W'(1) << (OUT_LSB - 1);

   localparam real PI = 3.14159265358979323846;

   // cos or sin of 2*pi*k/N in Q1.14, rounded to nearest; only ever
   // evaluated with constant arguments.
   function automatic logic signed [TW_W-1:0] tw_value(input int k, input int log2_n,
                                                       input bit want_sin);
      real ang;
      real v;
      ang = 2.0 * PI * real'(k) / real'(1 << log2_n);
      v   = (want_sin ? $sin(ang) : $cos(ang)) * real'(TW_ONE);
      return TW_W'($rtoi(v < 0.0 ? v - 0.5 : v + 0.5));
   endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Half-length twiddle table (k = 0..N/2-1) with a registered read port;
// contents are generated from fft_pkg::tw_value at elaboration.
module twiddle_rom
   import fft_pkg::*;
#(
   parameter int LOG2_N = 4
) (
   input  logic                   clk,
   input  logic [LOG2_N-2:0]      addr,
   output logic signed [TW_W-1:0] cos_q,
   output logic signed [TW_W-1:0] sin_q
);

   localparam int DEPTH = 1 << (LOG2_N - 1);

   logic signed [TW_W-1:0] cos_tab [DEPTH];
   logic signed [TW_W-1:0] sin_tab [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_tab
      assign cos_tab[i] = tw_value(i, LOG2_N, 1'b0);
      assign sin_tab[i] = tw_value(i, LOG2_N, 1'b1);
   end

   // NOTE: table and read register carry no reset; downstream valid flags
   // decide when the data matters, so resetting them buys nothing.
   always_ff @(posedge clk) begin
      cos_q <= cos_tab[addr];
      sin_q <= sin_tab[addr];
   end

endmodule

// File: rtl/twiddle_mult.sv
// Streaming twiddle multiplier: (a+jb) * W^k, 3-cycle latency, output at 1/2 scale.
// Define TWIDDLE_MULT_ROUND_EN to round half up instead of truncating.
module twiddle_mult
   import fft_pkg::*;
#(
   parameter int LOG2_N = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic                     tw_start,
   input  logic signed [DATA_W-1:0] Re_in,
   input  logic signed [DATA_W-1:0] Im_in,
   output logic                     out_valid,
   output logic signed [DATA_W-1:0] Re_out,
   output logic signed [DATA_W-1:0] Im_out
);

   localparam int KW = LOG2_N - 1;

   logic [KW-1:0]            k;
   logic [KW-1:0]            k_sel;
   logic [KW-1:0]            k_next;
   logic                     v1;
   logic                     v2;
   logic signed [DATA_W-1:0] a_q;
   logic signed [DATA_W-1:0] b_q;
   logic signed [TW_W-1:0]   cos_q;
   logic signed [TW_W-1:0]   sin_q;
   logic signed [PROD_W-1:0] ac;
   logic signed [PROD_W-1:0] bs;
   logic signed [PROD_W-1:0] bc;
   logic signed [PROD_W-1:0] as_p;
   logic [SUM_W-1:0]         re_sum;
   logic [SUM_W-1:0]         im_sum;
   logic                     unused_sum_bits;

   // The ROM is addressed with the index this sample uses, so its registered
   // output lines up with a_q/b_q.
   twiddle_rom #(.LOG2_N(LOG2_N)) u_rom (
      .clk   (clk),
      .addr  (k_sel),
      .cos_q (cos_q),
      .sin_q (sin_q)
   );

   // NOTE: every always_comb output gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      k_sel  = tw_start ? '0 : k;
      k_next = k;
      if (in_valid)
         k_next = k_sel + 1'b1;   // N/2 is a power of two: wraps for free
      else if (tw_start)
         k_next = '0;
   end

   // NOTE: combinational temporaries use blocking '=' so the rounding step
   // sees the sum computed just above; registers use '<=' only.
   always_comb begin
      re_sum = {ac[PROD_W-1], ac} + {bs[PROD_W-1], bs};
      im_sum = {bc[PROD_W-1], bc} - {as_p[PROD_W-1], as_p};
`ifdef TWIDDLE_MULT_ROUND_EN
      re_sum = re_sum + ROUND_BIAS;
      im_sum = im_sum + ROUND_BIAS;
`else
      re_sum = re_sum;
      im_sum = im_sum;
`endif
   end

   assign unused_sum_bits = ^{re_sum[SUM_W-1:OUT_LSB+DATA_W], re_sum[OUT_LSB-1:0],
                              im_sum[SUM_W-1:OUT_LSB+DATA_W], im_sum[OUT_LSB-1:0]};

   always_ff @(posedge clk) begin
      a_q  <= Re_in;
      b_q  <= Im_in;
      ac   <= PROD_W'(a_q) * PROD_W'(cos_q);
      bs   <= PROD_W'(b_q) * PROD_W'(sin_q);
      bc   <= PROD_W'(b_q) * PROD_W'(cos_q);
      as_p <= PROD_W'(a_q) * PROD_W'(sin_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k         <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         Re_out    <= '0;
         Im_out    <= '0;
      end else begin
         k         <= k_next;
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         if (v2) begin
            Re_out <= re_sum[OUT_LSB +: DATA_W];
            Im_out <= im_sum[OUT_LSB +: DATA_W];
         end
      end
   end

endmodule

// File: doc/twiddle_mult.md
TWIDDLE_MULT -- requirements
Module: twiddle_mult

Interface
REQ-001 SHALL have parameter LOG2_N, default 4, meaning log2 of FFT length N; legal range 2..10.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  sample present on Re_in/Im_in this cycle.
REQ-005 SHALL have port tw_start  input  1  restart twiddle index at 0.
REQ-006 SHALL have port Re_in  input  16  signed real part of sample.
REQ-007 SHALL have port Im_in  input  16  signed imaginary part of sample.
REQ-008 SHALL have port out_valid  output  1  Re_out/Im_out hold a product.
REQ-009 SHALL have port Re_out  output  16  signed real part of the scaled product, feeding the complex adder stage.
REQ-010 SHALL have port Im_out  output  16  signed imaginary part of the scaled product.

Function
REQ-011 SHALL multiply each valid sample (a+jb) by W^k = cos(2πk/N) − j·sin(2πk/N): Re = a·cos + b·sin, Im = b·cos − a·sin.
REQ-012 SHALL hold twiddles as signed 16-bit Q1.14 (1.0 = 16384), ROM depth N/2, index k in 0..N/2−1.
REQ-013 SHALL form each sum at full precision (33 bits) and output bits [30:15], giving a 1/2 scale that matches the adder stage; no saturation is needed.
REQ-014 SHALL have a fixed latency of 3 cycles: register input and ROM read, then the four products, then add/sub and scale; out_valid equals in_valid delayed by 3.
REQ-015 SHALL accept a sample every cycle; there is no backpressure. Bubbles propagate with out_valid=0.
REQ-016 SHALL hold Re_out/Im_out at their last value while out_valid=0.
REQ-017 SHALL advance k by 1 on each cycle with in_valid=1 and wrap from N/2−1 to 0.
REQ-018 SHALL make tw_start=1 with in_valid=1 use k=0 for that sample and set the next index to 1.
REQ-019 SHALL make tw_start=1 with in_valid=0 set the next index to 0.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, clear k, all pipeline valid flags, out_valid, Re_out and Im_out to 0.
REQ-021 SHALL discard samples in flight at reset; no out_valid may appear for them.
REQ-022 SHALL give rst priority over in_valid and tw_start in the same cycle.

Configuration
REQ-023 SHALL, with macro TWIDDLE_MULT_ROUND_EN defined, add 2^14 to each 33-bit sum before taking bits [30:15] (round half up).
REQ-024 SHALL, without TWIDDLE_MULT_ROUND_EN, truncate with no rounding, matching the adder stage. Latency is unchanged either way.

Structure
REQ-025 SHALL place DATA_W=16, TW_W=16 and TW_ONE=16384 in shared package fft_pkg.
REQ-026 SHALL implement the twiddle table as sub-module twiddle_rom (parameter LOG2_N, registered read, returns cos and sin), with contents computed at elaboration.

Verification
REQ-027 Reset: rst high 2 cycles with in_valid=1 -> out_valid=0, Re_out=0, Im_out=0 throughout and 3 cycles after.
REQ-028 k=0: tw_start=1, in_valid=1, (1000, −2000) -> 3 cycles later out_valid=1, (500, −1000).
REQ-029 k=4, N=16 (W=−j): input (1000, 0) as the 5th sample after tw_start -> (0, −500).
REQ-030 Extreme and wrap: (−32768, −32768) at k=2 (cos=sin=11585) -> (−23170, 0); the 9th consecutive sample after tw_start uses k=0 again.
REQ-031 Rounding: (1, 0) at k=0 -> (1, 0) with TWIDDLE_MULT_ROUND_EN, (0, 0) without.
REQ-032 Mid-stream reset: 5 back-to-back samples, rst pulsed at the 2nd -> no out_valid from the discarded samples; the next sample uses k=0.
